// File: rtl/phaser_out_pkg.sv
// rtl/phaser_out_pkg.sv - shared state codes, command kinds and parameter helpers for the output phaser
package phaser_out_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_APPLY  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_COARSE,
        CMD_FINE
    } cmd_e;

    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit str_true(input logic [39:0] s);
        return s == 40'("TRUE");
    endfunction

    function automatic bit str_valid(input logic [39:0] s);
        return (s == 40'("TRUE")) || (s == 40'("FALSE"));
    endfunction

endpackage

// File: rtl/phaser_clkdiv.sv
// rtl/phaser_clkdiv.sv - divided-clock strobe with phase slip, divider reset and OSERDES reset release
module phaser_clkdiv #(
    parameter int CLKOUT_DIV = 4,
    parameter bit EN_OSR     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_divrst,
    input  logic i_edgeadv,
    output logic o_strobe,
    output logic o_osr
);

    logic [3:0] r_cnt;
    logic       r_strobe;
    logic       r_osr;
    logic       r_seen;
    logic       w_wrap;

    // A phase slip parks the counter for one cycle, which also swallows a strobe due that cycle.
    assign w_wrap = (r_cnt == 4'(CLKOUT_DIV - 1)) && !i_edgeadv;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_divrst) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
            r_osr    <= EN_OSR;
            r_seen   <= 1'b0;
        end else begin
            r_strobe <= w_wrap;
            if (!i_edgeadv) begin
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            end
            // OSERDES reset is released together with the second strobe after release.
            if (w_wrap) begin
                r_seen <= 1'b1;
                if (r_seen) begin
                    r_osr <= 1'b0;
                end
            end
        end
    end

    assign o_strobe = r_strobe;
    assign o_osr    = r_osr;

endmodule

// File: rtl/phaser_out_lane_ctl.sv
// rtl/phaser_out_lane_ctl.sv - multi-lane fine/coarse tap controller with settle-timed command handshake
module phaser_out_lane_ctl
    import phaser_out_pkg::*;
#(
    parameter int NUM_LANES      = 4,
    parameter int FINE_W         = 6,
    parameter int COARSE_W       = 3,
    parameter int FINE_DELAY     = 0,
    parameter int COARSE_DELAY   = 0,
    parameter     COARSE_BYPASS  = "FALSE",
    parameter int CLKOUT_DIV     = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter     EN_OSERDES_RST = "FALSE"
) (
    input  logic                            SYSCLK,
    input  logic                            RST,
    input  logic [lane_w(NUM_LANES)-1:0]    LANESEL,
    input  logic                            FINEENABLE,
    input  logic                            FINEINC,
    input  logic                            COARSEENABLE,
    input  logic                            COARSEINC,
    input  logic                            COUNTERLOADEN,
    input  logic [COARSE_W+FINE_W-1:0]      COUNTERLOADVAL,
    input  logic                            COUNTERREADEN,
    input  logic                            DIVIDERST,
    input  logic                            EDGEADV,
    output logic [COARSE_W+FINE_W-1:0]      COUNTERREADVAL,
    output logic                            FINEOVERFLOW,
    output logic                            COARSEOVERFLOW,
    output logic                            BUSY,
    output logic                            OCLKDIV_EN,
    output logic                            OSERDESRST,
    output logic [NUM_LANES*FINE_W-1:0]     FINE_TAPS,
    output logic [NUM_LANES*COARSE_W-1:0]   COARSE_TAPS
);

    localparam int CNT_W  = COARSE_W + FINE_W;
    localparam int LSEL_W = lane_w(NUM_LANES);
    localparam bit BYPASS = str_true(40'(COARSE_BYPASS));
    localparam logic [FINE_W-1:0]   FINE_MAX   = '1;
    localparam logic [COARSE_W-1:0] COARSE_MAX = '1;
    localparam logic [FINE_W-1:0]   FINE_RST   = FINE_W'(FINE_DELAY);
    localparam logic [COARSE_W-1:0] COARSE_RST = BYPASS ? '0 : COARSE_W'(COARSE_DELAY);

    if (NUM_LANES < 1 || NUM_LANES > 16) begin : g_chk_lanes
        $fatal(1, "NUM_LANES must be 1..16");
    end
    if (FINE_W < 1 || COARSE_W < 1) begin : g_chk_widths
        $fatal(1, "FINE_W and COARSE_W must be at least 1");
    end
    if (FINE_DELAY < 0 || FINE_DELAY > (1 << FINE_W) - 1) begin : g_chk_fine_delay
        $fatal(1, "FINE_DELAY out of range");
    end
    if (COARSE_DELAY < 0 || COARSE_DELAY > (1 << COARSE_W) - 1) begin : g_chk_coarse_delay
        $fatal(1, "COARSE_DELAY out of range");
    end
    if (CLKOUT_DIV < 2 || CLKOUT_DIV > 16) begin : g_chk_div
        $fatal(1, "CLKOUT_DIV must be 2..16");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_chk_settle
        $fatal(1, "SETTLE_CYCLES must be 1..255");
    end
    if (!str_valid(40'(COARSE_BYPASS)) || !str_valid(40'(EN_OSERDES_RST))) begin : g_chk_str
        $fatal(1, "COARSE_BYPASS and EN_OSERDES_RST must be \"TRUE\" or \"FALSE\"");
    end

    logic [FINE_W-1:0]   r_fine   [NUM_LANES];
    logic [COARSE_W-1:0] r_coarse [NUM_LANES];
    logic [1:0]          r_state;
    cmd_e                r_cmd;
    logic                r_dir;
    logic [LSEL_W-1:0]   r_lane;
    logic [CNT_W-1:0]    r_loadval;
    logic [7:0]          r_settle;
    logic                r_busy;
    logic                r_fine_ovf;
    logic                r_coarse_ovf;
    logic [CNT_W-1:0]    r_readval;
    logic                w_lane_ok;
    cmd_e                w_cmd;

    assign w_lane_ok = int'(LANESEL) < NUM_LANES;

    always_comb begin
        w_cmd = CMD_NONE;
        if (COUNTERLOADEN) begin
            w_cmd = CMD_LOAD;
        end else if (COARSEENABLE && !BYPASS) begin
            w_cmd = CMD_COARSE;
        end else if (FINEENABLE) begin
            w_cmd = CMD_FINE;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_cmd        <= CMD_NONE;
            r_dir        <= 1'b0;
            r_lane       <= '0;
            r_loadval    <= '0;
            r_settle     <= '0;
            r_busy       <= 1'b0;
            r_fine_ovf   <= 1'b0;
            r_coarse_ovf <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_fine[i]   <= FINE_RST;
                r_coarse[i] <= COARSE_RST;
            end
        end else begin
            r_fine_ovf <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd != CMD_NONE && w_lane_ok) begin
                        r_state   <= ST_APPLY;
                        r_busy    <= 1'b1;
                        r_cmd     <= w_cmd;
                        r_dir     <= (w_cmd == CMD_COARSE) ? COARSEINC : FINEINC;
                        r_lane    <= LANESEL;
                        r_loadval <= COUNTERLOADVAL;
                    end
                end
                ST_APPLY: begin
                    r_state  <= ST_SETTLE;
                    r_settle <= 8'(SETTLE_CYCLES - 1);
                    case (r_cmd)
                        CMD_LOAD: begin
                            r_fine[r_lane] <= r_loadval[FINE_W-1:0];
                            if (!BYPASS) begin
                                r_coarse[r_lane] <= r_loadval[CNT_W-1:FINE_W];
                            end
                            r_coarse_ovf <= 1'b0;
                        end
                        CMD_COARSE: begin
                            // A saturated step changes nothing but still flags and settles.
                            if (r_dir ? (r_coarse[r_lane] == COARSE_MAX) : (r_coarse[r_lane] == '0)) begin
                                r_coarse_ovf <= 1'b1;
                            end else begin
                                r_coarse[r_lane] <= r_dir ? r_coarse[r_lane] + 1'b1 : r_coarse[r_lane] - 1'b1;
                                r_coarse_ovf     <= 1'b0;
                            end
                        end
                        CMD_FINE: begin
                            r_fine[r_lane] <= r_dir ? r_fine[r_lane] + 1'b1 : r_fine[r_lane] - 1'b1;
                            r_fine_ovf     <= r_dir ? (r_fine[r_lane] == FINE_MAX) : (r_fine[r_lane] == '0);
                        end
                        default: ;
                    endcase
                end
                ST_SETTLE: begin
                    if (r_settle == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Reads bypass the handshake; a read in the update cycle sees the old value.
    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            r_readval <= '0;
        end else if (COUNTERREADEN && w_lane_ok) begin
            r_readval <= {r_coarse[LANESEL], r_fine[LANESEL]};
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_taps
        assign FINE_TAPS[g*FINE_W +: FINE_W]       = r_fine[g];
        assign COARSE_TAPS[g*COARSE_W +: COARSE_W] = r_coarse[g];
    end

    phaser_clkdiv #(
        .CLKOUT_DIV (CLKOUT_DIV),
        .EN_OSR     (str_true(40'(EN_OSERDES_RST)))
    ) u_clkdiv (
        .i_clk     (SYSCLK),
        .i_rst     (RST),
        .i_divrst  (DIVIDERST),
        .i_edgeadv (EDGEADV),
        .o_strobe  (OCLKDIV_EN),
        .o_osr     (OSERDESRST)
    );

    assign COUNTERREADVAL = r_readval;
    assign FINEOVERFLOW   = r_fine_ovf;
    assign COARSEOVERFLOW = r_coarse_ovf;
    assign BUSY           = r_busy;

endmodule

// File: tb/tb_phaser_out_lane_ctl.sv
// tb/tb_phaser_out_lane_ctl.sv - scoreboard bench with a lane/tap reference model for phaser_out_lane_ctl
module tb_phaser_out_lane_ctl;

    logic        SYSCLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  LANESEL = '0;
    logic        FINEENABLE = 1'b0, FINEINC = 1'b0;
    logic        COARSEENABLE = 1'b0, COARSEINC = 1'b0;
    logic        COUNTERLOADEN = 1'b0;
    logic [8:0]  COUNTERLOADVAL = '0;
    logic        COUNTERREADEN = 1'b0;
    logic        DIVIDERST = 1'b0, EDGEADV = 1'b0;
    logic [8:0]  COUNTERREADVAL;
    logic        FINEOVERFLOW, COARSEOVERFLOW, BUSY, OCLKDIV_EN, OSERDESRST;
    logic [23:0] FINE_TAPS;
    logic [11:0] COARSE_TAPS;

    always #5 SYSCLK = ~SYSCLK;

    phaser_out_lane_ctl #(
        .NUM_LANES      (4),
        .FINE_W         (6),
        .COARSE_W       (3),
        .FINE_DELAY     (5),
        .COARSE_DELAY   (2),
        .COARSE_BYPASS  ("FALSE"),
        .CLKOUT_DIV     (4),
        .SETTLE_CYCLES  (8),
        .EN_OSERDES_RST ("TRUE")
    ) dut (
        .SYSCLK         (SYSCLK),
        .RST            (RST),
        .LANESEL        (LANESEL),
        .FINEENABLE     (FINEENABLE),
        .FINEINC        (FINEINC),
        .COARSEENABLE   (COARSEENABLE),
        .COARSEINC      (COARSEINC),
        .COUNTERLOADEN  (COUNTERLOADEN),
        .COUNTERLOADVAL (COUNTERLOADVAL),
        .COUNTERREADEN  (COUNTERREADEN),
        .DIVIDERST      (DIVIDERST),
        .EDGEADV        (EDGEADV),
        .COUNTERREADVAL (COUNTERREADVAL),
        .FINEOVERFLOW   (FINEOVERFLOW),
        .COARSEOVERFLOW (COARSEOVERFLOW),
        .BUSY           (BUSY),
        .OCLKDIV_EN     (OCLKDIV_EN),
        .OSERDESRST     (OSERDESRST),
        .FINE_TAPS      (FINE_TAPS),
        .COARSE_TAPS    (COARSE_TAPS)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];
    int         mf[4];
    int         mc[4];
    int         mco;
    logic       rd_d = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge SYSCLK);
    endtask

    // Monitor: a read issued at one edge presents its value after that edge.
    always @(posedge SYSCLK) rd_d <= COUNTERREADEN;

    initial begin
        forever begin
            @(negedge SYSCLK);
            if (rd_d) begin
                if (exp_q.size() == 0) check("read_queue_depth", exp_q.size(), 1);
                else check("readval", int'(COUNTERREADVAL), int'(exp_q.pop_front()));
            end
        end
    end

    function automatic int model_fine_taps();
        int r = 0;
        for (int i = 0; i < 4; i++) r += mf[i] << (6 * i);
        return r;
    endfunction

    function automatic int model_coarse_taps();
        int r = 0;
        for (int i = 0; i < 4; i++) r += mc[i] << (3 * i);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mf[i] = 5;
            mc[i] = 2;
        end
        mco = 0;
    endtask

    task automatic rd(input int lane);
        LANESEL = 2'(lane);
        COUNTERREADEN = 1'b1;
        exp_q.push_back(9'(mc[lane] * 64 + mf[lane]));
        tick();
        COUNTERREADEN = 1'b0;
    endtask

    // Ticks until the next strobe; optionally slips the divider on the first of them.
    task automatic gap(input bit adv, output int k);
        EDGEADV = adv;
        tick();
        EDGEADV = 1'b0;
        k = 1;
        while (!OCLKDIV_EN && k < 40) begin
            tick();
            k++;
        end
    endtask

    task automatic do_cmd(input bit ld, input bit co, input bit fi, input bit dir,
                          input int lane, input logic [8:0] lv, input bit poke);
        int busy_n, ovf_n, wrap, pre;
        pre  = mc[lane] * 64 + mf[lane];
        wrap = 0;
        if (ld) begin
            mc[lane] = int'(lv) / 64;
            mf[lane] = int'(lv) % 64;
            mco = 0;
        end else if (co) begin
            if (dir ? (mc[lane] == 7) : (mc[lane] == 0)) mco = 1;
            else begin
                mc[lane] = mc[lane] + (dir ? 1 : -1);
                mco = 0;
            end
        end else if (fi) begin
            wrap = dir ? int'(mf[lane] == 63) : int'(mf[lane] == 0);
            mf[lane] = (mf[lane] + (dir ? 1 : 63)) % 64;
        end
        LANESEL = 2'(lane);
        COUNTERLOADEN = ld; COARSEENABLE = co; FINEENABLE = fi;
        COARSEINC = dir; FINEINC = dir; COUNTERLOADVAL = lv;
        tick();
        COUNTERLOADEN = 1'b0; COARSEENABLE = 1'b0; FINEENABLE = 1'b0;
        busy_n = 0;
        ovf_n  = 0;
        while (BUSY && busy_n < 40) begin
            busy_n++;
            if (FINEOVERFLOW) ovf_n++;
            COUNTERREADEN = (busy_n == 1);
            if (busy_n == 1) exp_q.push_back(9'(pre));
            if (poke && busy_n == 9) begin
                COUNTERLOADEN = 1'b1; COARSEENABLE = 1'b1; FINEENABLE = 1'b1;
                COUNTERLOADVAL = 9'h0AA;
            end
            tick();
        end
        COUNTERLOADEN = 1'b0; COARSEENABLE = 1'b0; FINEENABLE = 1'b0; COUNTERREADEN = 1'b0;
        check("busy_cycles", busy_n, 9);
        check("fine_ovf_pulses", ovf_n, wrap);
        check("coarse_ovf", int'(COARSEOVERFLOW), mco);
        check("fine_tap", int'(FINE_TAPS[lane*6 +: 6]), mf[lane]);
        check("coarse_tap", int'(COARSE_TAPS[lane*3 +: 3]), mc[lane]);
    endtask

    initial begin
        int k;
        repeat (3) tick();
        RST = 1'b0;
        model_reset();
        check("rst_busy", int'(BUSY), 0);
        check("rst_fine_ovf", int'(FINEOVERFLOW), 0);
        check("rst_coarse_ovf", int'(COARSEOVERFLOW), 0);
        check("rst_strobe", int'(OCLKDIV_EN), 0);
        check("rst_osr", int'(OSERDESRST), 1);
        check("rst_readval", int'(COUNTERREADVAL), 0);
        check("rst_fine_taps", int'(FINE_TAPS), model_fine_taps());
        check("rst_coarse_taps", int'(COARSE_TAPS), model_coarse_taps());

        gap(1'b0, k); check("first_strobe_gap", k, 4); check("osr_strobe1", int'(OSERDESRST), 1);
        gap(1'b0, k); check("second_strobe_gap", k, 4); check("osr_strobe2", int'(OSERDESRST), 0);
        gap(1'b1, k); check("edgeadv_gap", k, 5);
        gap(1'b0, k); check("post_adv_gap", k, 4);
        DIVIDERST = 1'b1;
        tick();
        EDGEADV = 1'b1;
        tick();
        check("divrst_osr", int'(OSERDESRST), 1);
        check("divrst_strobe", int'(OCLKDIV_EN), 0);
        EDGEADV = 1'b0;
        tick();
        DIVIDERST = 1'b0;
        gap(1'b0, k); check("divrst_first_gap", k, 4); check("divrst_osr_s1", int'(OSERDESRST), 1);
        gap(1'b0, k); check("divrst_second_gap", k, 4); check("divrst_osr_s2", int'(OSERDESRST), 0);

        for (int l = 0; l < 4; l++) rd(l);

        do_cmd(1'b1, 1'b0, 1'b0, 1'b0, 2, 9'h03F, 1'b0);
        do_cmd(1'b0, 1'b0, 1'b1, 1'b1, 2, 9'h000, 1'b1);
        rd(2);
        do_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1, 9'h1CA, 1'b0);
        do_cmd(1'b0, 1'b1, 1'b0, 1'b1, 1, 9'h000, 1'b0);
        do_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1, 9'h000, 1'b0);
        rd(1);
        do_cmd(1'b1, 1'b0, 1'b1, 1'b1, 3, 9'h1A3, 1'b0);
        check("lane3_load_taps", int'({COARSE_TAPS[11:9], FINE_TAPS[23:18]}), 9'h1A3);
        rd(3);

        LANESEL = 2'd0; FINEENABLE = 1'b1; FINEINC = 1'b1;
        tick();
        FINEENABLE = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model_reset();
        check("settle_rst_busy", int'(BUSY), 0);
        check("settle_rst_fine", int'(FINE_TAPS), model_fine_taps());
        check("settle_rst_coarse", int'(COARSE_TAPS), model_coarse_taps());
        do_cmd(1'b0, 1'b0, 1'b1, 1'b0, 1, 9'h000, 1'b0);
        rd(1);

        repeat (40) begin
            bit ld, co, fi;
            ld = ($urandom_range(0, 4) == 0);
            co = ($urandom_range(0, 2) == 0);
            fi = 1'($urandom_range(0, 1));
            if (!(ld || co || fi)) fi = 1'b1;
            do_cmd(ld, co, fi, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   9'($urandom), 1'($urandom_range(0, 1)));
            rd(int'($urandom_range(0, 3)));
        end

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
